// File: rtl/handshake_constant_rom.sv
// Handshake constant ROM: each accepted control token emits one table entry through a 2-slot elastic buffer.
// Optional statistics (tok_count, overflow_seen) are enabled by defining HANDSHAKE_CONST_ROM_STATS_EN.
module handshake_constant_rom #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int MODE       = 0,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_WIDTH-1:0]  ctrl_index,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
`ifdef HANDSHAKE_CONST_ROM_STATS_EN
  output logic [15:0]           tok_count,
  output logic                  overflow_seen,
`endif
  output logic                  err
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_ctrlReady;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_inRange;
  logic [DATA_WIDTH-1:0] w_value;

  assign w_accept   = ctrl_valid & r_ctrlReady;
  assign w_xfer     = outs_valid & outs_ready;
  assign ctrl_ready = r_ctrlReady;
  assign outs_valid = (r_state != S_EMPTY);
  assign outs       = r_main;
  assign err        = r_err;

  // Table lookup: an out-of-range index leaves w_value at zero and w_inRange low.
  always_comb begin
    w_value   = '0;
    w_inRange = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ({1'b0, ctrl_index} == i[IDX_WIDTH:0]) begin
          w_value   = INIT[i*DATA_WIDTH +: DATA_WIDTH];
          w_inRange = 1'b1;
        end
      end
    end else begin
      w_inRange = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_cnt == i[CNT_W-1:0]) w_value = INIT[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_next = S_ONE;
      S_ONE: begin
        if (w_accept && !w_xfer)      w_next = S_TWO;
        else if (!w_accept && w_xfer) w_next = S_EMPTY;
      end
      S_TWO:   if (w_xfer) w_next = S_ONE;
      default: w_next = S_EMPTY;
    endcase
  end

  // ctrl_ready is registered from the next state so it never depends on outs_ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_ctrlReady <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ctrlReady <= (w_next != S_TWO);
      if (w_accept && (r_state == S_EMPTY || (r_state == S_ONE && w_xfer))) r_main <= w_value;
      else if (r_state == S_TWO && w_xfer) r_main <= r_skid;
      if (w_accept && r_state == S_ONE && !w_xfer) r_skid <= w_value;
      if (MODE != 0 && w_accept) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      if (MODE == 0 && w_accept && !w_inRange) r_err <= 1'b1;
    end
  end

`ifdef HANDSHAKE_CONST_ROM_STATS_EN
  logic [15:0] r_tokCount;
  logic        r_overflow;

  assign tok_count     = r_tokCount;
  assign overflow_seen = r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tokCount <= '0;
      r_overflow <= 1'b0;
    end else if (w_xfer) begin
      r_tokCount <= r_tokCount + 16'd1;
      if (r_tokCount == 16'hFFFF) r_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_constant_rom.sv
// Bench for handshake_constant_rom: three instances (indexed, short table, sequential) with per-instance scoreboards.
// Define HANDSHAKE_CONST_ROM_STATS_EN to also exercise tok_count / overflow_seen.
module tb_handshake_constant_rom;

  localparam logic [35:0] ENTRY [4] = '{36'h6DC59362C, 36'h1, 36'hFFFFFFFFF, 36'h0A5};
  localparam logic [4*36-1:0] INIT4 = {36'h0A5, 36'hFFFFFFFFF, 36'h1, 36'h6DC59362C};
  localparam logic [3*36-1:0] INIT3 = {36'hFFFFFFFFF, 36'h1, 36'h6DC59362C};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  aIdx = '0, bIdx = '0, cIdx = '0;
  logic        aValid = 1'b0, bValid = 1'b0, cValid = 1'b0;
  logic        aOutsReady = 1'b1, bOutsReady = 1'b1, cOutsReady = 1'b1;
  logic        aReady, bReady, cReady;
  logic        aOutsValid, bOutsValid, cOutsValid;
  logic        aErr, bErr, cErr;
  logic [35:0] aOuts, bOuts, cOuts;
`ifdef HANDSHAKE_CONST_ROM_STATS_EN
  logic [15:0] aTok, bTok, cTok;
  logic        aOvf, bOvf, cOvf;
`endif

  handshake_constant_rom #(.DATA_WIDTH(36), .DEPTH(4), .IDX_WIDTH(2), .MODE(0), .INIT(INIT4)) dutA (
    .clk(clk), .rst(rst), .ctrl_index(aIdx), .ctrl_valid(aValid), .ctrl_ready(aReady),
    .outs(aOuts), .outs_valid(aOutsValid), .outs_ready(aOutsReady),
`ifdef HANDSHAKE_CONST_ROM_STATS_EN
    .tok_count(aTok), .overflow_seen(aOvf),
`endif
    .err(aErr));

  handshake_constant_rom #(.DATA_WIDTH(36), .DEPTH(3), .IDX_WIDTH(2), .MODE(0), .INIT(INIT3)) dutB (
    .clk(clk), .rst(rst), .ctrl_index(bIdx), .ctrl_valid(bValid), .ctrl_ready(bReady),
    .outs(bOuts), .outs_valid(bOutsValid), .outs_ready(bOutsReady),
`ifdef HANDSHAKE_CONST_ROM_STATS_EN
    .tok_count(bTok), .overflow_seen(bOvf),
`endif
    .err(bErr));

  handshake_constant_rom #(.DATA_WIDTH(36), .DEPTH(4), .IDX_WIDTH(2), .MODE(1), .INIT(INIT4)) dutC (
    .clk(clk), .rst(rst), .ctrl_index(cIdx), .ctrl_valid(cValid), .ctrl_ready(cReady),
    .outs(cOuts), .outs_valid(cOutsValid), .outs_ready(cOutsReady),
`ifdef HANDSHAKE_CONST_ROM_STATS_EN
    .tok_count(cTok), .overflow_seen(cOvf),
`endif
    .err(cErr));

  int checkCount = 0;
  int passCount  = 0;
  logic [35:0] qA[$], qB[$], qC[$];
  int cCnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: at mid-cycle, pop on a pending transfer then push on a pending accept.
  always @(negedge clk) begin
    if (!rst) qA.delete();
    else begin
      if (aOutsValid && aOutsReady) begin
        if (qA.size() == 0) checkOutput("A_unexpected_token", aOuts, 64'hDEAD);
        else checkOutput("A_scoreboard", aOuts, qA.pop_front());
      end
      if (aValid && aReady) qA.push_back(ENTRY[aIdx]);
    end
  end

  always @(negedge clk) begin
    if (!rst) qB.delete();
    else begin
      if (bOutsValid && bOutsReady) begin
        if (qB.size() == 0) checkOutput("B_unexpected_token", bOuts, 64'hDEAD);
        else checkOutput("B_scoreboard", bOuts, qB.pop_front());
      end
      if (bValid && bReady) qB.push_back((bIdx < 2'd3) ? ENTRY[bIdx] : 36'h0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      qC.delete();
      cCnt = 0;
    end else begin
      if (cOutsValid && cOutsReady) begin
        if (qC.size() == 0) checkOutput("C_unexpected_token", cOuts, 64'hDEAD);
        else checkOutput("C_scoreboard", cOuts, qC.pop_front());
      end
      if (cValid && cReady) begin
        qC.push_back(ENTRY[cCnt]);
        cCnt = (cCnt + 1) % 4;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog timeout");
  end

  typedef struct {
    logic        valid;
    logic [1:0]  idx;
    logic        oReady;
    logic        expValid;
    logic [35:0] expOuts;
    logic        expReady;
  } vecT;

  vecT vecs[11];

  task automatic applyStimulus(input vecT v);
    aValid     = v.valid;
    aIdx       = v.idx;
    aOutsReady = v.oReady;
  endtask

  initial begin
    // Back-to-back stream, then backpressure holding two tokens in the buffer.
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b1, 36'h6DC59362C, 1'b1};
    vecs[1]  = '{1'b1, 2'd1, 1'b1, 1'b1, 36'h1,         1'b1};
    vecs[2]  = '{1'b1, 2'd2, 1'b1, 1'b1, 36'hFFFFFFFFF, 1'b1};
    vecs[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 36'h0A5,       1'b1};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 36'h0A5,       1'b1};
    vecs[5]  = '{1'b1, 2'd3, 1'b0, 1'b1, 36'h0A5,       1'b1};
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 1'b1, 36'h0A5,       1'b0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b1, 36'h0A5,       1'b0};
    vecs[8]  = '{1'b1, 2'd1, 1'b1, 1'b1, 36'hFFFFFFFFF, 1'b1};
    vecs[9]  = '{1'b1, 2'd1, 1'b1, 1'b1, 36'h1,         1'b1};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 36'h1,         1'b1};

    #2;
    checkOutput("reset_outs", aOuts, 0);
    checkOutput("reset_outs_valid", aOutsValid, 0);
    checkOutput("reset_ctrl_ready", aReady, 0);
    checkOutput("reset_err", aErr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("ready_after_release", aReady, 1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("A_vec%0d_valid", i), aOutsValid, vecs[i].expValid);
      checkOutput($sformatf("A_vec%0d_outs", i), aOuts, vecs[i].expOuts);
      checkOutput($sformatf("A_vec%0d_ready", i), aReady, vecs[i].expReady);
      checkOutput($sformatf("A_vec%0d_err", i), aErr, 0);
    end

    // Out-of-range index on a 3-entry table.
    bValid = 1'b1; bIdx = 2'd2;
    tick();
    checkOutput("B_err_inrange", bErr, 0);
    bIdx = 2'd3;
    tick();
    checkOutput("B_err_set", bErr, 1);
    checkOutput("B_oor_outs", bOuts, 0);
    checkOutput("B_oor_valid", bOutsValid, 1);
    bIdx = 2'd0;
    tick();
    checkOutput("B_err_sticky0", bErr, 1);
    bIdx = 2'd1;
    tick();
    bValid = 1'b0;
    checkOutput("B_err_sticky1", bErr, 1);
    tick();

    // Sequential mode: index is ignored, counter walks the table.
    cOutsReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cValid = 1'b1;
      cIdx   = 2'($urandom_range(0, 3));
      tick();
    end
    cValid = 1'b0;
    tick();
    cOutsReady = 1'b0;
    cValid = 1'b1;
    tick();
    tick();
    cValid = 1'b0;
    checkOutput("C_two_ready", cReady, 0);
    checkOutput("C_two_valid", cOutsValid, 1);
    checkOutput("C_two_hold", cOuts, ENTRY[3]);

    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async_valid", cOutsValid, 0);
    checkOutput("rst_async_outs", cOuts, 0);
    checkOutput("rst_async_ready", cReady, 0);
    checkOutput("rst_async_err", bErr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("C_ready_after_rst", cReady, 1);
    cOutsReady = 1'b1;
    cValid = 1'b1;
    tick();
    cValid = 1'b0;
    checkOutput("C_post_reset_entry0", cOuts, ENTRY[0]);
    checkOutput("C_post_reset_valid", cOutsValid, 1);
    tick();

`ifdef HANDSHAKE_CONST_ROM_STATS_EN
    checkOutput("stats_after_rst", aTok, 0);
    aIdx = 2'd0; aOutsReady = 1'b1; aValid = 1'b1;
    repeat (65535) tick();
    aValid = 1'b0;
    tick();
    checkOutput("stats_tok_ffff", aTok, 16'hFFFF);
    checkOutput("stats_ovf_before", aOvf, 0);
    aValid = 1'b1;
    tick();
    tick();
    aValid = 1'b0;
    tick();
    checkOutput("stats_tok_wrap", aTok, 1);
    checkOutput("stats_ovf_after", aOvf, 1);
`endif

    tick();
    checkOutput("A_queue_drained", qA.size(), 0);
    checkOutput("B_queue_drained", qB.size(), 0);
    checkOutput("C_queue_drained", qC.size(), 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
